// File: rtl/rf_write_arbiter_if.sv
// Bundle between the register-file write requesters (wb / irq / dbg), the
// write arbiter, and the regfile write port it drives.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_req;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ack;
    logic              irq_req;
    logic [DATA_W-1:0] irq_data;
    logic              irq_ack;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ack;
    logic              rf_werf;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wdata;
    logic              starved;

    modport slave (
        input  wb_req, wb_addr, wb_data,
        input  irq_req, irq_data,
        input  dbg_req, dbg_addr, dbg_data,
        output wb_ack, irq_ack, dbg_ack,
        output rf_werf, rf_wa, rf_wdata, starved
    );

    modport master (
        output wb_req, wb_addr, wb_data,
        output irq_req, irq_data,
        output dbg_req, dbg_addr, dbg_data,
        input  wb_ack, irq_ack, dbg_ack,
        input  rf_werf, rf_wa, rf_wdata, starved
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: wb > irq > dbg, with a starvation escape for dbg.
// Optional macro RF_R0_PROTECT_EN: writes to R0 are acked but suppressed like R31.
module rf_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clock,
    input  logic               reset,
    rf_write_arbiter_if.slave  rf_bus
);
    localparam logic [0:0] ST_ARB       = 1'b0;
    localparam logic [0:0] ST_FORCE_DBG = 1'b1;

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] XP_ADDR = ADDR_W'(30);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wb_ack_q, irq_ack_q, dbg_ack_q;
    logic              werf_q, werf_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic wb_el, irq_el, dbg_el;
    logic gnt_wb, gnt_irq, gnt_dbg, any_gnt;
    logic discard;

    // A requester whose ack is up this cycle already issued; don't grant it twice.
    assign wb_el  = rf_bus.wb_req  & ~wb_ack_q;
    assign irq_el = rf_bus.irq_req & ~irq_ack_q;
    assign dbg_el = rf_bus.dbg_req & ~dbg_ack_q;

    always_comb begin
        gnt_wb  = 1'b0;
        gnt_irq = 1'b0;
        gnt_dbg = 1'b0;
        if (state_q == ST_FORCE_DBG) begin
            if (dbg_el)      gnt_dbg = 1'b1;
            else if (wb_el)  gnt_wb  = 1'b1;
            else if (irq_el) gnt_irq = 1'b1;
        end else begin
            if (wb_el)       gnt_wb  = 1'b1;
            else if (irq_el) gnt_irq = 1'b1;
            else if (dbg_el) gnt_dbg = 1'b1;
        end
    end

    assign any_gnt = gnt_wb | gnt_irq | gnt_dbg;

    always_comb begin
        wa_d    = wa_q;
        wdata_d = wdata_q;
        if (gnt_wb) begin
            wa_d    = rf_bus.wb_addr;
            wdata_d = rf_bus.wb_data;
        end else if (gnt_irq) begin
            wa_d    = XP_ADDR;
            wdata_d = rf_bus.irq_data;
        end else if (gnt_dbg) begin
            wa_d    = rf_bus.dbg_addr;
            wdata_d = rf_bus.dbg_data;
        end
    end

`ifdef RF_R0_PROTECT_EN
    // R0 is reloaded by the regfile every cycle, so a write there is meaningless.
    assign discard = (wa_d == '1) || (wa_d == '0);
`else
    assign discard = (wa_d == '1);
`endif

    assign werf_d = any_gnt & ~discard;

    always_comb begin
        cnt_d = cnt_q;
        if (!rf_bus.dbg_req || gnt_dbg)
            cnt_d = '0;
        else if (dbg_el && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:
                if (cnt_q == CNT_MAX && rf_bus.dbg_req && !gnt_dbg)
                    state_d = ST_FORCE_DBG;
            ST_FORCE_DBG:
                if (gnt_dbg || !rf_bus.dbg_req)
                    state_d = ST_ARB;
            default:
                state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_ARB;
            cnt_q     <= '0;
            wb_ack_q  <= 1'b0;
            irq_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            werf_q    <= 1'b0;
            wa_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_ack_q  <= gnt_wb;
            irq_ack_q <= gnt_irq;
            dbg_ack_q <= gnt_dbg;
            werf_q    <= werf_d;
            wa_q      <= wa_d;
            wdata_q   <= wdata_d;
        end
    end

    assign rf_bus.wb_ack   = wb_ack_q;
    assign rf_bus.irq_ack  = irq_ack_q;
    assign rf_bus.dbg_ack  = dbg_ack_q;
    assign rf_bus.rf_werf  = werf_q;
    assign rf_bus.rf_wa    = wa_q;
    assign rf_bus.rf_wdata = wdata_q;
    assign rf_bus.starved  = (state_q == ST_FORCE_DBG);
endmodule
